// File: rtl/lfsr_burst_sched_if.sv
// Handshake bundle for lfsr_burst_sched: requester side, external LFSR side and output stream.
// slave is the scheduler's view; master is the view of the environment that drives it.
interface lfsr_burst_sched_if #(
    parameter int width     = 8,
    parameter int num_req   = 4,
    parameter int len_width = 4
);
    logic [num_req-1:0]           req;
    logic [num_req*width-1:0]     seed;
    logic [num_req*len_width-1:0] len;
    logic [num_req-1:0]           gnt;
    logic                         busy;
    logic [width-1:0]             lfsr_data;
    logic                         lfsr_load;
    logic                         lfsr_cen;
    logic [width-1:0]             lfsr_count;
    logic [width-1:0]             out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [1:0]                   out_id;

    modport slave (
        input  req, seed, len, lfsr_count, out_ready,
        output gnt, busy, lfsr_data, lfsr_load, lfsr_cen, out_data, out_valid, out_id
    );

    modport master (
        output req, seed, len, lfsr_count, out_ready,
        input  gnt, busy, lfsr_data, lfsr_load, lfsr_cen, out_data, out_valid, out_id
    );
endinterface

// File: rtl/lfsr_burst_sched.sv
// Round-robin scheduler sharing one loadable LFSR among up to 4 requesters;
// each grant loads the winner's seed and streams len words with valid/ready.
module lfsr_burst_sched #(
    parameter int width     = 8,
    parameter int num_req   = 4,
    parameter int len_width = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    lfsr_burst_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_ptr;
    logic [num_req-1:0]   r_gnt;
    logic [width-1:0]     r_seed;
    logic [len_width-1:0] r_len;
    logic [len_width-1:0] r_rem;
    logic [3:0]           w_req4;
    logic [1:0]           w_win;
    logic                 w_found;
    logic                 w_accept;

    function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
        return 2'((int'(p) + k) % num_req);
    endfunction

    // Pad to 4 bits so the 2-bit round-robin index is always in range.
    assign w_req4 = 4'(bus.req);

    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 1; k <= num_req; k++) begin
            if (!w_found && w_req4[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        bus.lfsr_load = 1'b1;
        bus.lfsr_cen  = 1'b0;
        bus.lfsr_data = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_id    = '0;
        case (r_state)
            IDLE: if (w_found) w_state_nxt = LOAD;
            LOAD: begin
                // A zero-length grant still consumes its turn but never touches the LFSR.
                if (r_len != '0) begin
                    bus.lfsr_load = 1'b0;
                    bus.lfsr_cen  = 1'b1;
                    bus.lfsr_data = r_seed;
                    w_state_nxt   = RUN;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            RUN: begin
                bus.out_valid = 1'b1;
                bus.out_data  = bus.lfsr_count;
                bus.out_id    = r_ptr;
                w_accept      = bus.out_ready;
                bus.lfsr_cen  = w_accept;
                if (w_accept && r_rem == len_width'(1)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.gnt  = r_gnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_ptr   <= 2'(num_req - 1);
            r_gnt   <= '0;
            r_seed  <= '0;
            r_len   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= '0;
            if (r_state == IDLE && w_found) begin
                r_ptr  <= w_win;
                r_gnt  <= num_req'(1) << w_win;
                r_seed <= bus.seed[w_win*width +: width];
                r_len  <= bus.len[w_win*len_width +: len_width];
            end
            if (r_state == LOAD)
                r_rem <= r_len;
            else if (w_accept)
                r_rem <= r_rem - 1'b1;
        end
    end
endmodule

// File: tb/tb_lfsr_burst_sched.sv
// Directed bench for lfsr_burst_sched with an attached 8-bit loadable LFSR model
// (x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0).
module tb_lfsr_burst_sched;
    localparam int W  = 8;
    localparam int NR = 4;
    localparam int LW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [W-1:0] lfsr;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    lfsr_burst_sched_if #(.width(W), .num_req(NR), .len_width(LW)) bus();

    lfsr_burst_sched #(.width(W), .num_req(NR), .len_width(LW)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    always @(posedge clk) begin
        if (!rst)                lfsr <= '0;
        else if (!bus.lfsr_load) lfsr <= bus.lfsr_data;
        else if (bus.lfsr_cen)   lfsr <= lfsr_next(lfsr);
    end
    assign bus.lfsr_count = lfsr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] s, input logic [LW-1:0] l);
        bus.seed[i*W +: W]  = s;
        bus.len[i*LW +: LW] = l;
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.req = '0; bus.seed = '0; bus.len = '0; bus.out_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if ({bus.gnt, bus.busy, bus.lfsr_load, bus.lfsr_cen, bus.lfsr_data} !== {4'b0000, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got gnt=%b busy=%b load=%b cen=%b data=%h, want 0000 0 1 0 00",
                     bus.gnt, bus.busy, bus.lfsr_load, bus.lfsr_cen, bus.lfsr_data);
        end
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_id} !== {1'b0, 8'h00, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_out: got valid=%b data=%h id=%0d, want 0 00 0", bus.out_valid, bus.out_data, bus.out_id);
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [W-1:0] exp_w [3] = '{8'h01, 8'h02, 8'h04};
        set_slot(0, 8'h01, 4'd3); bus.out_ready = 1'b1; bus.req = 4'b0001;
        n_checks++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++; $display("FAIL single_idle_gnt: got %b want 0000", bus.gnt);
        end
        tick();
        n_checks++;
        if ({bus.gnt, bus.lfsr_load, bus.lfsr_cen, bus.lfsr_data, bus.out_valid, bus.busy} !== {4'b0001, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_load: got gnt=%b load=%b cen=%b data=%h valid=%b busy=%b, want 0001 0 1 01 0 1",
                     bus.gnt, bus.lfsr_load, bus.lfsr_cen, bus.lfsr_data, bus.out_valid, bus.busy);
        end
        bus.req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({bus.out_valid, bus.out_data, bus.out_id, bus.lfsr_cen, bus.gnt} !== {1'b1, exp_w[i], 2'd0, 1'b1, 4'b0000}) begin
                n_fail++;
                $display("FAIL single_word%0d: got valid=%b data=%h id=%0d cen=%b gnt=%b, want 1 %h 0 1 0000",
                         i, bus.out_valid, bus.out_data, bus.out_id, bus.lfsr_cen, bus.gnt, exp_w[i]);
            end
        end
        tick();
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.gnt, bus.lfsr_cen} !== {1'b0, 1'b0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL single_end: got valid=%b busy=%b gnt=%b cen=%b, want 0 0 0000 0",
                     bus.out_valid, bus.busy, bus.gnt, bus.lfsr_cen);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] s;
        rst = 1'b0; bus.req = 4'b1111; bus.out_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_slot(i, 8'(8'h11 * (i + 1)), 4'd1);
        tick();
        rst = 1'b1;
        for (int g = 0; g < 5; g++) begin
            s = 8'(8'h11 * (g % 4 + 1));
            tick();
            n_checks++;
            if ({bus.gnt, bus.lfsr_data} !== {4'(1 << (g % 4)), s}) begin
                n_fail++;
                $display("FAIL rr_gnt%0d: got gnt=%b data=%h, want %b %h", g, bus.gnt, bus.lfsr_data, 4'(1 << (g % 4)), s);
            end
            tick();
            n_checks++;
            if ({bus.out_valid, bus.out_data, bus.out_id} !== {1'b1, s, 2'(g % 4)}) begin
                n_fail++;
                $display("FAIL rr_word%0d: got valid=%b data=%h id=%0d, want 1 %h %0d", g, bus.out_valid, bus.out_data, bus.out_id, s, g % 4);
            end
            tick();
            n_checks++;
            if ({bus.out_valid, bus.busy, bus.gnt} !== {1'b0, 1'b0, 4'b0000}) begin
                n_fail++;
                $display("FAIL rr_bubble%0d: got valid=%b busy=%b gnt=%b, want 0 0 0000", g, bus.out_valid, bus.busy, bus.gnt);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_w [4] = '{8'h80, 8'h01, 8'h02, 8'h04};
        logic [6:0]   pat = 7'b1011001;
        int           acc = 0;
        int           seen = 0;
        set_slot(1, 8'h80, 4'd4); bus.req = 4'b0010;
        tick();
        n_checks++;
        if ({bus.gnt, bus.lfsr_load, bus.lfsr_data} !== {4'b0010, 1'b0, 8'h80}) begin
            n_fail++;
            $display("FAIL bp_load: got gnt=%b load=%b data=%h, want 0010 0 80", bus.gnt, bus.lfsr_load, bus.lfsr_data);
        end
        bus.req = '0;
        for (int i = 0; i < 7; i++) begin
            tick();
            bus.out_ready = pat[i];
            #1;
            n_checks++;
            if ({bus.out_valid, bus.out_data, bus.out_id, bus.lfsr_cen} !== {1'b1, exp_w[acc], 2'd1, pat[i]}) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: got valid=%b data=%h id=%0d cen=%b, want 1 %h 1 %b",
                         i, bus.out_valid, bus.out_data, bus.out_id, bus.lfsr_cen, exp_w[acc], pat[i]);
            end
            if (bus.out_valid && bus.out_ready) seen++;
            if (pat[i]) acc++;
        end
        tick();
        bus.out_ready = 1'b1;
        n_checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL bp_end: got valid=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
        end
        n_checks++;
        if (seen !== 4) begin
            n_fail++; $display("FAIL bp_count: got %0d words, want 4", seen);
        end
    endtask

    task automatic test_zero_len();
        set_slot(2, 8'hAA, 4'd0); set_slot(3, 8'h03, 4'd2); bus.req = 4'b1100;
        tick();
        n_checks++;
        if ({bus.gnt, bus.lfsr_load, bus.lfsr_cen, bus.lfsr_data, bus.busy, bus.out_valid} !== {4'b0100, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL zl_gnt2: got gnt=%b load=%b cen=%b data=%h busy=%b valid=%b, want 0100 1 0 00 1 0",
                     bus.gnt, bus.lfsr_load, bus.lfsr_cen, bus.lfsr_data, bus.busy, bus.out_valid);
        end
        bus.req = 4'b1000;
        tick();
        n_checks++;
        if ({bus.gnt, bus.busy, bus.out_valid} !== {4'b0000, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL zl_idle: got gnt=%b busy=%b valid=%b, want 0000 0 0", bus.gnt, bus.busy, bus.out_valid);
        end
        tick();
        n_checks++;
        if ({bus.gnt, bus.lfsr_load, bus.lfsr_data} !== {4'b1000, 1'b0, 8'h03}) begin
            n_fail++; $display("FAIL zl_gnt3: got gnt=%b load=%b data=%h, want 1000 0 03", bus.gnt, bus.lfsr_load, bus.lfsr_data);
        end
        bus.req = '0;
        tick();
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_id} !== {1'b1, 8'h03, 2'd3}) begin
            n_fail++; $display("FAIL zl_word0: got valid=%b data=%h id=%0d, want 1 03 3", bus.out_valid, bus.out_data, bus.out_id);
        end
        tick();
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_id} !== {1'b1, 8'h06, 2'd3}) begin
            n_fail++; $display("FAIL zl_word1: got valid=%b data=%h id=%0d, want 1 06 3", bus.out_valid, bus.out_data, bus.out_id);
        end
        tick();
        n_checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL zl_end: got valid=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp_w [5] = '{8'h05, 8'h0A, 8'h15, 8'h2B, 8'h56};
        set_slot(0, 8'h05, 4'd15); bus.req = 4'b0001; bus.out_ready = 1'b1;
        tick();
        bus.req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, exp_w[i]}) begin
                n_fail++; $display("FAIL rm_word%0d: got valid=%b data=%h, want 1 %h", i, bus.out_valid, bus.out_data, exp_w[i]);
            end
        end
        rst = 1'b0; bus.req = 4'b0011; set_slot(0, 8'h05, 4'd1); set_slot(1, 8'h77, 4'd1);
        tick();
        n_checks++;
        if ({bus.out_valid, bus.lfsr_cen, bus.lfsr_load, bus.busy, bus.gnt} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL rm_abort: got valid=%b cen=%b load=%b busy=%b gnt=%b, want 0 0 1 0 0000",
                     bus.out_valid, bus.lfsr_cen, bus.lfsr_load, bus.busy, bus.gnt);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++; $display("FAIL rm_ptr: got gnt=%b, want 0001", bus.gnt);
        end
        bus.req = '0;
        tick(); tick();
        n_checks++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL rm_drain: got valid=%b busy=%b, want 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_withdrawn();
        logic seen1 = 1'b0;
        set_slot(0, 8'h01, 4'd3); bus.req = 4'b0001;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0001) begin
            n_fail++; $display("FAIL wd_gnt0: got gnt=%b, want 0001", bus.gnt);
        end
        bus.req = '0;
        tick();
        bus.req = 4'b0010;
        seen1 = seen1 | bus.gnt[1];
        tick();
        bus.req = '0;
        for (int i = 0; i < 6; i++) begin
            seen1 = seen1 | bus.gnt[1];
            tick();
        end
        n_checks++;
        if ({seen1, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL wd_no_gnt1: got seen_gnt1=%b busy=%b, want 0 0", seen1, bus.busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_withdrawn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
